// File: rtl/ctrl_pipe_unit.sv
// Registered ID-stage control unit: decodes op_code into the ID/EX control register and
// sequences hazard bubbles, branch flush windows and a multi-cycle MUL.
module ctrl_pipe_unit #(
  parameter int OPW          = 6,
  parameter int EXEW         = 4,
  parameter int MUL_LAT      = 4,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [OPW-1:0]  op_code,
  input  logic            hazard_detected,
  input  logic            branch_taken,
  output logic            stall_out,
  output logic            flush_out,
  output logic            mul_busy,
  output logic            ex_valid,
  output logic [EXEW-1:0] exe_cmd,
  output logic [1:0]      branch_command,
  output logic            branch_en,
  output logic            is_imm,
  output logic            st_or_bne,
  output logic            wb_en,
  output logic            mem_r_en,
  output logic            mem_w_en
);

  typedef enum logic [1:0] {RUN, MUL_WAIT, FLUSH} state_t;

  typedef struct packed {
    logic            ex_valid;
    logic [EXEW-1:0] exe_cmd;
    logic [1:0]      branch_command;
    logic            branch_en;
    logic            is_imm;
    logic            st_or_bne;
    logic            wb_en;
    logic            mem_r_en;
    logic            mem_w_en;
  } ctrl_t;

  localparam int CNT_MAX = (MUL_LAT > FLUSH_CYCLES) ? MUL_LAT : FLUSH_CYCLES;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [OPW-1:0] OP_MUL = OPW'(13);

  function automatic ctrl_t alu_op(input int cmd);
    ctrl_t d;
    d          = '0;
    d.ex_valid = 1'b1;
    d.exe_cmd  = EXEW'(cmd);
    d.wb_en    = 1'b1;
    return d;
  endfunction

  function automatic ctrl_t br_op(input int bc);
    ctrl_t d;
    d                = '0;
    d.ex_valid       = 1'b1;
    d.exe_cmd        = EXEW'(15);
    d.is_imm         = 1'b1;
    d.branch_en      = 1'b1;
    d.branch_command = 2'(bc);
    return d;
  endfunction

  function automatic ctrl_t decode(input logic vld, input logic [OPW-1:0] op);
    ctrl_t       d;
    logic [31:0] opi;
    d   = '0;
    opi = 32'(op);
    if (vld) begin
      case (opi)
        32'd1:         d = alu_op(0);
        32'd3:         d = alu_op(2);
        32'd5:         d = alu_op(4);
        32'd6:         d = alu_op(5);
        32'd7:         d = alu_op(6);
        32'd8:         d = alu_op(7);
        32'd9, 32'd10: d = alu_op(8);
        32'd11:        d = alu_op(9);
        32'd12:        d = alu_op(10);
        32'd13:        d = alu_op(11);
        32'd32:        begin d = alu_op(0); d.is_imm = 1'b1; end
        32'd33:        begin d = alu_op(2); d.is_imm = 1'b1; end
        32'd36: begin
          d           = alu_op(0);
          d.is_imm    = 1'b1;
          d.st_or_bne = 1'b1;
          d.mem_r_en  = 1'b1;
        end
        32'd37: begin
          d           = alu_op(0);
          d.wb_en     = 1'b0;
          d.is_imm    = 1'b1;
          d.st_or_bne = 1'b1;
          d.mem_w_en  = 1'b1;
        end
        32'd40:        d = br_op(3);
        32'd41:        begin d = br_op(1); d.st_or_bne = 1'b1; end
        32'd42:        d = br_op(2);
        default:       d = '0;
      endcase
    end
    return d;
  endfunction

  state_t            state_p1;
  logic [CNT_W-1:0]  cnt_p1;
  ctrl_t             ctrl_p1;
  logic              mul_busy_p1;
  ctrl_t             dec_p0;
  logic              is_mul_p0;
  logic              take_dec_p0;

  // ID: decode is taken in RUN without a hazard, or on the last MUL_WAIT edge
  always_comb begin
    dec_p0      = decode(valid_in, op_code);
    is_mul_p0   = valid_in & (op_code == OP_MUL);
    take_dec_p0 = ~branch_taken &
                  (((state_p1 == RUN) & ~hazard_detected) |
                   ((state_p1 == MUL_WAIT) & (cnt_p1 == CNT_W'(1))));
  end

  // ID/EX control register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1    <= RUN;
      cnt_p1      <= '0;
      ctrl_p1     <= '0;
      mul_busy_p1 <= 1'b0;
    end else if (branch_taken) begin
      ctrl_p1     <= '0;
      mul_busy_p1 <= 1'b0;
      if (FLUSH_CYCLES > 1) begin
        state_p1 <= FLUSH;
        cnt_p1   <= CNT_W'(FLUSH_CYCLES - 1);
      end else begin
        state_p1 <= RUN;
        cnt_p1   <= '0;
      end
    end else if (take_dec_p0) begin
      ctrl_p1 <= dec_p0;
      if (is_mul_p0 && (MUL_LAT > 1)) begin
        state_p1    <= MUL_WAIT;
        cnt_p1      <= CNT_W'(MUL_LAT - 1);
        mul_busy_p1 <= 1'b1;
      end else begin
        state_p1    <= RUN;
        cnt_p1      <= '0;
        mul_busy_p1 <= 1'b0;
      end
    end else begin
      case (state_p1)
        FLUSH: begin
          ctrl_p1 <= '0;
          if (cnt_p1 == CNT_W'(1)) begin
            state_p1 <= RUN;
            cnt_p1   <= '0;
          end else begin
            cnt_p1 <= cnt_p1 - CNT_W'(1);
          end
        end
        MUL_WAIT: begin
          // EXE keeps the MUL; only its issue/writeback strobes drop
          cnt_p1           <= cnt_p1 - CNT_W'(1);
          ctrl_p1.ex_valid <= 1'b0;
          ctrl_p1.wb_en    <= 1'b0;
        end
        default: ctrl_p1 <= '0;
      endcase
    end
  end

  assign stall_out = (state_p1 == MUL_WAIT) |
                     ((state_p1 == RUN) & hazard_detected & ~branch_taken);
  assign flush_out = branch_taken | (state_p1 == FLUSH);
  assign mul_busy  = mul_busy_p1;

  assign {ex_valid, exe_cmd, branch_command, branch_en, is_imm,
          st_or_bne, wb_en, mem_r_en, mem_w_en} = ctrl_p1;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Scoreboard bench for ctrl_pipe_unit: two instances (MUL_LAT=4/FLUSH_CYCLES=3 and 1/1)
// share one randomized stimulus stream and are checked against a table-driven reference model.
module tb_ctrl_pipe_unit;

  logic       clk = 1'b0;
  logic       rst, valid_in, hazard_detected, branch_taken;
  logic [5:0] op_code;

  always #5 clk = ~clk;

  logic       stall_a, flush_a, busy_a, exv_a, bre_a, imm_a, sb_a, wb_a, mr_a, mw_a;
  logic [3:0] cmd_a;
  logic [1:0] bc_a;
  logic       stall_b, flush_b, busy_b, exv_b, bre_b, imm_b, sb_b, wb_b, mr_b, mw_b;
  logic [3:0] cmd_b;
  logic [1:0] bc_b;

  ctrl_pipe_unit #(.OPW(6), .EXEW(4), .MUL_LAT(4), .FLUSH_CYCLES(3)) u_a (
    .clk(clk), .rst(rst), .valid_in(valid_in), .op_code(op_code),
    .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .stall_out(stall_a), .flush_out(flush_a), .mul_busy(busy_a), .ex_valid(exv_a),
    .exe_cmd(cmd_a), .branch_command(bc_a), .branch_en(bre_a), .is_imm(imm_a),
    .st_or_bne(sb_a), .wb_en(wb_a), .mem_r_en(mr_a), .mem_w_en(mw_a));

  ctrl_pipe_unit #(.OPW(6), .EXEW(4), .MUL_LAT(1), .FLUSH_CYCLES(1)) u_b (
    .clk(clk), .rst(rst), .valid_in(valid_in), .op_code(op_code),
    .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .stall_out(stall_b), .flush_out(flush_b), .mul_busy(busy_b), .ex_valid(exv_b),
    .exe_cmd(cmd_b), .branch_command(bc_b), .branch_en(bre_b), .is_imm(imm_b),
    .st_or_bne(sb_b), .wb_en(wb_b), .mem_r_en(mr_b), .mem_w_en(mw_b));

  // Reference model: per instance, remaining flush / stall cycles and the expected control word.
  // Control word layout: {ex_valid, exe_cmd[3:0], branch_command[1:0], be, imm, sb, wb, mr, mw}
  int          ml[2] = '{4, 1};
  int          fc[2] = '{3, 1};
  logic [12:0] tbl[64];
  logic [12:0] m_regs[2];
  logic [12:0] m_held[2];
  logic        m_busy[2];
  int          m_frem[2];
  int          m_mrem[2];

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int          vectors = 0;
  int          miss    = 0;

  int ops[22] = '{1, 3, 5, 6, 7, 8, 9, 10, 11, 12, 32, 33, 36, 37, 40, 41, 42, 13, 2, 63, 0, 13};

  task automatic tset(input int op, input int cmd, input int bc, input logic [5:0] fl);
    tbl[op] = {1'b1, 4'(cmd), 2'(bc), fl};
  endtask

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_regs[i] = '0; m_held[i] = '0; m_busy[i] = 1'b0; m_frem[i] = 0; m_mrem[i] = 0;
    end
  endtask

  task automatic m_decode(input int i, input logic v, input int op);
    m_regs[i] = v ? tbl[op] : 13'h0;
    m_mrem[i] = 0;
    m_busy[i] = 1'b0;
    if (v && op == 13 && ml[i] > 1) begin
      m_mrem[i] = ml[i] - 1;
      m_busy[i] = 1'b1;
      m_held[i] = m_regs[i];
    end
  endtask

  task automatic m_edge(input int i, input logic r, input logic v, input int op,
                        input logic hz, input logic bt);
    if (r) begin
      m_regs[i] = '0; m_busy[i] = 1'b0; m_frem[i] = 0; m_mrem[i] = 0;
    end else if (bt) begin
      m_regs[i] = '0; m_busy[i] = 1'b0; m_mrem[i] = 0; m_frem[i] = fc[i] - 1;
    end else if (m_frem[i] > 0) begin
      m_regs[i] = '0;
      m_frem[i]--;
    end else if (m_mrem[i] > 1) begin
      m_mrem[i]--;
      m_regs[i] = m_held[i] & ~13'h1004;
    end else if (m_mrem[i] == 1 || !hz) begin
      m_decode(i, v, op);
    end else begin
      m_regs[i] = '0;
    end
  endtask

  task automatic cyc(input logic r, input logic v, input int op, input logic hz, input logic bt);
    logic st, fl;
    rst = r; valid_in = v; op_code = 6'(op); hazard_detected = hz; branch_taken = bt;
    for (int i = 0; i < 2; i++) begin
      fl = bt || (m_frem[i] > 0);
      st = (m_mrem[i] > 0) || (m_frem[i] == 0 && hz && !bt);
      if (i == 0) q0.push_back({m_regs[i], m_busy[i], st, fl});
      else        q1.push_back({m_regs[i], m_busy[i], st, fl});
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) m_edge(i, r, v, op, hz, bt);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act[15:2] !== exp[15:2]) begin
      miss++;
      $display("FAIL %s_ctrl t=%0t actual=%h required=%h", name, $time, act[15:2], exp[15:2]);
    end
    vectors++;
    if (act[1] !== exp[1]) begin
      miss++;
      $display("FAIL %s_stall t=%0t actual=%b required=%b", name, $time, act[1], exp[1]);
    end
    vectors++;
    if (act[0] !== exp[0]) begin
      miss++;
      $display("FAIL %s_flush t=%0t actual=%b required=%b", name, $time, act[0], exp[0]);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (q0.size() > 0)
      chk("a", {exv_a, cmd_a, bc_a, bre_a, imm_a, sb_a, wb_a, mr_a, mw_a, busy_a, stall_a, flush_a},
          q0.pop_front());
    if (q1.size() > 0)
      chk("b", {exv_b, cmd_b, bc_b, bre_b, imm_b, sb_b, wb_b, mr_b, mw_b, busy_b, stall_b, flush_b},
          q1.pop_front());
  end

  initial begin
    for (int k = 0; k < 64; k++) tbl[k] = '0;
    tset(1, 0, 0, 6'b000100);  tset(3, 2, 0, 6'b000100);  tset(5, 4, 0, 6'b000100);
    tset(6, 5, 0, 6'b000100);  tset(7, 6, 0, 6'b000100);  tset(8, 7, 0, 6'b000100);
    tset(9, 8, 0, 6'b000100);  tset(10, 8, 0, 6'b000100); tset(11, 9, 0, 6'b000100);
    tset(12, 10, 0, 6'b000100); tset(13, 11, 0, 6'b000100);
    tset(32, 0, 0, 6'b010100); tset(33, 2, 0, 6'b010100);
    tset(36, 0, 0, 6'b011110); tset(37, 0, 0, 6'b011001);
    tset(40, 15, 3, 6'b110000); tset(41, 15, 1, 6'b111000); tset(42, 15, 2, 6'b110000);

    rst = 1'b1; valid_in = 1'b1; op_code = 6'd1; hazard_detected = 1'b0; branch_taken = 1'b0;
    @(posedge clk);
    m_reset();
    #1;

    // Reset held with a live opcode, then release
    cyc(1, 1, 1, 0, 0); cyc(1, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0); cyc(0, 1, 3, 0, 0);

    // Decode sweep (MUL handled separately) and an invalid slot
    for (int k = 0; k < 22; k++) if (ops[k] != 13) cyc(0, 1, ops[k], 0, 0);
    cyc(0, 0, 36, 0, 0); cyc(0, 1, 1, 0, 0);

    // Load followed by a one-cycle hazard
    cyc(0, 1, 36, 0, 0); cyc(0, 1, 36, 1, 0); cyc(0, 1, 1, 0, 0); cyc(0, 1, 1, 0, 0);

    // MUL, with a hazard during the wait that must be ignored
    cyc(0, 1, 13, 0, 0); cyc(0, 1, 3, 0, 0); cyc(0, 1, 3, 1, 0); cyc(0, 1, 3, 0, 0);
    cyc(0, 1, 3, 0, 0); cyc(0, 1, 1, 0, 0);

    // Branch pulse, then a second pulse in the next cycle
    cyc(0, 1, 1, 0, 1); cyc(0, 1, 1, 0, 1);
    repeat (4) cyc(0, 1, 5, 0, 0);

    // Branch during MUL_WAIT cycle 2
    cyc(0, 1, 13, 0, 0); cyc(0, 1, 1, 0, 0); cyc(0, 1, 1, 0, 1);
    repeat (4) cyc(0, 1, 6, 0, 0);

    // Reset during MUL_WAIT
    cyc(0, 1, 13, 0, 0); cyc(0, 1, 1, 0, 0); cyc(1, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0); cyc(0, 1, 7, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      int   op;
      logic r, v, hz, bt;
      op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : ops[$urandom_range(0, 21)];
      r  = ($urandom_range(0, 99) < 2);
      v  = ($urandom_range(0, 9) != 0);
      hz = ($urandom_range(0, 4) == 0);
      bt = ($urandom_range(0, 99) < 8);
      cyc(r, v, op, hz, bt);
    end

    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (q0.size() + q1.size() != 0) begin
      miss++;
      $display("FAIL drain actual=%0d records left required=0", q0.size() + q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule
